key_matrix_scanner: RTL and testbench
=====================================

Name: key_matrix_scanner

Overview:
- Reads a 4x4 membrane keypad: drives one column low at a time and samples the four row lines.
- Debounces the full 16-key snapshot, then reports single-key presses as a 4-bit code through a valid/ack handshake.
- Input-side counterpart of the team's 16x16 dot-matrix column/row scan drivers; feeds the display-sequencing logic that selects which glyph is shown.

Parameters:
- SCAN_DIV, 1000, clock cycles each column stays driven (>=2); rows sampled on the last cycle of the period.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan snapshots required before the snapshot is accepted as stable (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- key_row  in  4  row inputs; active low (pulled up externally), asynchronous to clk.
- key_col  out  4  column drive; active low, exactly one bit low outside reset.
- key_code  out  4  code of reported key = col_index*4 + row_index.
- key_valid  out  1  high while a reported press awaits acknowledge.
- key_ack  in  1  consumer acknowledge; sampled only while key_valid=1.
- key_held  out  1  high while the stable snapshot has exactly one key pressed.
- multi_key  out  1  high while the stable snapshot has two or more keys pressed.
- overrun  out  1  sticky; set when a new press is detected while key_valid=1; cleared by reset.

Behaviour:
- Reset (rst_n=0 at a clock edge): key_col=4'b1110, column index=0, divider=0, key_code=0, key_valid=0, key_held=0, multi_key=0, overrun=0, snapshots=all released, debounce count=0, FSM=IDLE. Reset mid-scan or mid-handshake discards everything; no report is generated for keys already held at reset release until they pass debounce.
- Synchroniser: key_row passes through a 2-flop synchroniser before any use. Synchronised value is inverted so that 1 means pressed.
- Scan timing:
  - The divider counts 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, the synchronised rows are written into snapshot bits [col*4 +: 4], then the column advances 0->1->2->3->0. key_col = ~(1<<col).
  - A full scan is 4*SCAN_DIV cycles.
- Debounce, evaluated when column 3 is sampled (end of scan):
  - If the new snapshot equals the previous raw snapshot, the count increments (saturating at DEBOUNCE_SCANS); otherwise the count resets to 1.
  - When the count reaches DEBOUNCE_SCANS, the stable snapshot is updated to the new snapshot.
- Classification of the stable snapshot: popcount 0 = NONE, 1 = SINGLE, >=2 = MULTI. key_held = SINGLE; multi_key = MULTI. Both are registered and update in the cycle after the stable snapshot changes.
- FSM states IDLE, REPORT, HOLD:
  - IDLE: on transition to SINGLE, latch key_code from the one-hot position, set key_valid=1, go to REPORT. MULTI stays in IDLE and reports nothing.
  - REPORT: key_valid=1. key_ack=1 clears key_valid on the next edge. Then go to HOLD if the snapshot is still SINGLE/MULTI, or to IDLE if it is NONE.
  - HOLD: no further reports. Return to IDLE only when the stable snapshot becomes NONE. Rollover (SINGLE->MULTI->different SINGLE without release) produces no report.
- Handshake rules:
  - key_code is stable while key_valid=1.
  - key_ack while key_valid=0 is ignored.
  - Release before ack: key_valid stays high until acked; the FSM then goes to IDLE.
  - A release plus new press (NONE then SINGLE, both stable) while key_valid=1 sets overrun. key_code is not overwritten; the new press is lost.
- Latency: the first press report appears 1 cycle after the stable snapshot update. Worst case is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 4 cycles after the row edge.

Decomposition:
- Package key_scan_pkg holds:
  - the FSM state enum (IDLE, REPORT, HOLD);
  - constants NUM_COLS=4, NUM_ROWS=4, CODE_W=4;
  - function onehot_to_code(16-bit)->4-bit;
  - function popcount_class(16-bit)->{NONE, SINGLE, MULTI}.
- One sub-module, key_debounce: snapshot compare, debounce counter and stable register. Parameter DEBOUNCE_SCANS; inputs snapshot and scan_done; output stable snapshot plus a one-cycle stable_changed strobe.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
- Reset, no keys: key_col cycles 1110,1101,1011,0111 every 4 cycles. key_valid, key_held and multi_key stay 0 for 500 cycles.
- Hold row1 low whenever col2 is driven, ack 5 cycles after valid: key_valid rises with key_code=9, falls 1 cycle after ack, key_held=1; no second report while held.
- Bounce: toggle row0 on col0 every 20 cycles for 200 cycles, then release: no key_valid ever; key_held stays 0.
- Press code 5 and code 10 together: multi_key=1, key_valid=0. Release code 10 only: still no report (HOLD rollover rule).
- Press 3, hold ack low, release, press 12: key_valid stays high with key_code=3 and overrun=1. After ack, no report for 12 until it is released and pressed again.
- Assert rst_n=0 for 1 cycle during REPORT: outputs return to reset values next cycle. The held key is re-reported after debounce with the same code.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package key_scan_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        KC_NONE   = 2'd0,
        KC_SINGLE = 2'd1,
        KC_MULTI  = 2'd2
    } key_class_t;

    // Position of the set bit in a one-hot snapshot (col*4 + row).
    function automatic logic [CODE_W-1:0] onehot_to_code(input logic [NUM_KEYS-1:0] onehot);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (onehot[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

    // Classify a snapshot by how many keys are pressed.
    function automatic key_class_t popcount_class(input logic [NUM_KEYS-1:0] snap);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            ones = ones + {31'b0, snap[i]};
        end
        if (ones == 0)      return KC_NONE;
        else if (ones == 1) return KC_SINGLE;
        else                return KC_MULTI;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Accepts a full-scan snapshot only after it repeats for DEBOUNCE_SCANS scans.
module key_debounce
    import key_scan_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] snapshot,
    input  logic                scan_done,
    output logic [NUM_KEYS-1:0] stable,
    output logic                stable_changed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] prev_raw;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next_c;

    // Saturating repeat counter; any difference restarts the run at one.
    always_comb begin
        count_next_c = CNT_W'(1);
        if (snapshot == prev_raw) begin
            count_next_c = (count == CNT_MAX) ? count : count + CNT_W'(1);
        end
    end

    // Raw history, run length and the accepted stable snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_raw       <= '0;
            count          <= '0;
            stable         <= '0;
            stable_changed <= 1'b0;
        end else begin
            stable_changed <= 1'b0;
            if (scan_done) begin
                prev_raw <= snapshot;
                count    <= count_next_c;
                if (count_next_c == CNT_MAX) begin
                    stable         <= snapshot;
                    stable_changed <= (snapshot != stable);
                end
            end
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 keypad scanner: column drive, row sampling, debounce and single-key reporting.
module key_matrix_scanner
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                multi_key,
    output logic                overrun
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = $clog2(NUM_COLS);

    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;
    logic [DIV_W-1:0]    div;
    logic [COL_W-1:0]    col;
    logic [COL_W-1:0]    col_next_c;
    logic [NUM_KEYS-1:0] raw_snap;
    logic [NUM_KEYS-1:0] full_snap_c;
    logic [NUM_KEYS-1:0] stable;
    logic                stable_changed;
    logic                sample_c;
    logic                scan_done_c;
    logic                new_press_c;
    key_class_t          cls_c;

    scan_state_t         state;
    scan_state_t         state_next;
    logic                valid_next;
    logic                overrun_next;
    logic [CODE_W-1:0]   code_next;

    // Two-flop synchroniser for the asynchronous row lines (idle = released).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    assign sample_c    = (div == DIV_W'(SCAN_DIV - 1));
    assign scan_done_c = sample_c && (col == COL_W'(NUM_COLS - 1));
    assign col_next_c  = col + COL_W'(1);

    // Snapshot including the rows being sampled right now (1 = pressed).
    always_comb begin
        full_snap_c = raw_snap;
        full_snap_c[col*NUM_ROWS +: NUM_ROWS] = ~row_sync;
    end

    // Column divider, column rotation and raw snapshot capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div      <= '0;
            col      <= '0;
            key_col  <= 4'b1110;
            raw_snap <= '0;
        end else if (sample_c) begin
            div      <= '0;
            col      <= col_next_c;
            key_col  <= ~(NUM_COLS'(1) << col_next_c);
            raw_snap <= full_snap_c;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    key_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk            (clk),
        .rst_n          (rst_n),
        .snapshot       (full_snap_c),
        .scan_done      (scan_done_c),
        .stable         (stable),
        .stable_changed (stable_changed)
    );

    assign cls_c = popcount_class(stable);

    // A press is only a NONE -> SINGLE step; held/multi still show the old class here.
    assign new_press_c = stable_changed && (cls_c == KC_SINGLE) && !key_held && !multi_key;

    // Report FSM next state and next register values.
    always_comb begin
        state_next   = state;
        valid_next   = key_valid;
        code_next    = key_code;
        overrun_next = overrun;
        case (state)
            ST_IDLE: begin
                if (new_press_c) begin
                    valid_next = 1'b1;
                    code_next  = onehot_to_code(stable);
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (new_press_c) overrun_next = 1'b1;
                if (key_ack) begin
                    valid_next = 1'b0;
                    state_next = (cls_c == KC_NONE) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cls_c == KC_NONE) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state, handshake outputs and classification flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_next;
            key_valid <= valid_next;
            key_code  <= code_next;
            overrun   <= overrun_next;
            key_held  <= (cls_c == KC_SINGLE);
            multi_key <= (cls_c == KC_MULTI);
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a keypad model and expected-code queue.
module tb_key_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        multi_key;
    logic        overrun;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        seen_valid;
    logic        seen_held;
    logic        seen_multi;

    always #5 clk = ~clk;

    key_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .multi_key (multi_key),
        .overrun   (overrun)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (key_col[c] == 1'b0) key_row = ~pressed[c*4 +: 4];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        seen_valid = 1'b0;
        seen_held  = 1'b0;
        seen_multi = 1'b0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            seen_valid = seen_valid | key_valid;
            seen_held  = seen_held  | key_held;
            seen_multi = seen_multi | multi_key;
        end
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_col"},     32'(key_col),   32'hE);
        chk({tag, "_valid"},   32'(key_valid), 32'h0);
        chk({tag, "_code"},    32'(key_code),  32'h0);
        chk({tag, "_held"},    32'(key_held),  32'h0);
        chk({tag, "_multi"},   32'(multi_key), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun),   32'h0);
    endtask

    // Bounded wait for key_valid, then compare against the oldest queued code.
    task automatic wait_report(input string tag);
        int          n;
        logic [31:0] exp;
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(key_valid), 32'h1);
        if (key_valid === 1'b1) begin
            exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 'x;
            chk({tag, "_code"}, 32'(key_code), exp);
        end
    endtask

    initial begin
        logic [3:0] ecol;

        rst_n   = 1'b0;
        key_ack = 1'b0;
        pressed = '0;
        clear_seen();
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;

        // Column rotation, four cycles per column.
        for (int i = 0; i < 16; i++) begin
            ecol = ~(4'b0001 << (i / 4));
            chk("col_rotate", 32'(key_col), 32'(ecol));
            tick();
        end

        // Idle keypad stays silent.
        clear_seen();
        watch(500);
        chk("idle_valid", 32'(seen_valid), 32'h0);
        chk("idle_held",  32'(seen_held),  32'h0);
        chk("idle_multi", 32'(seen_multi), 32'h0);

        // Single press: col2 row1 -> code 9.
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_report("code9");
        chk("code9_held", 32'(key_held), 32'h1);
        repeat (5) tick();
        ack_pulse();
        chk("code9_ackclr", 32'(key_valid), 32'h0);
        clear_seen();
        watch(100);
        chk("code9_norepeat", 32'(seen_valid), 32'h0);
        chk("code9_stillheld", 32'(key_held), 32'h1);
        pressed = '0;
        watch(100);
        chk("code9_released", 32'(key_held), 32'h0);

        // Bouncing contact never reaches a stable press.
        clear_seen();
        for (int k = 0; k < 10; k++) begin
            pressed[0] = ~pressed[0];
            watch(20);
        end
        pressed = '0;
        watch(100);
        chk("bounce_valid", 32'(seen_valid), 32'h0);
        chk("bounce_held",  32'(seen_held),  32'h0);

        // Two keys together, then rollover to one of them.
        clear_seen();
        pressed[5]  = 1'b1;
        pressed[10] = 1'b1;
        watch(100);
        chk("multi_flag",  32'(multi_key),  32'h1);
        chk("multi_valid", 32'(seen_valid), 32'h0);
        pressed[10] = 1'b0;
        watch(100);
        chk("rollover_valid", 32'(seen_valid), 32'h0);
        chk("rollover_held",  32'(key_held),   32'h1);
        chk("rollover_multi", 32'(multi_key),  32'h0);
        pressed = '0;
        watch(100);
        chk("rollover_released", 32'(key_held), 32'h0);

        // Release and new press before ack sets overrun and keeps the first code.
        pressed[3] = 1'b1;
        exp_q.push_back(4'd3);
        wait_report("code3");
        pressed[3] = 1'b0;
        watch(100);
        pressed[12] = 1'b1;
        watch(100);
        chk("ovr_valid",   32'(key_valid), 32'h1);
        chk("ovr_code",    32'(key_code),  32'h3);
        chk("ovr_overrun", 32'(overrun),   32'h1);
        ack_pulse();
        chk("ovr_ackclr", 32'(key_valid), 32'h0);
        clear_seen();
        watch(100);
        chk("ovr_lost_press", 32'(seen_valid), 32'h0);
        pressed[12] = 1'b0;
        watch(100);
        pressed[12] = 1'b1;
        exp_q.push_back(4'd12);
        wait_report("code12");
        ack_pulse();
        pressed = '0;
        watch(100);

        // Reset during a pending report, then the held key is reported again.
        pressed[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_report("code6");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("midreset");
        exp_q.push_back(4'd6);
        wait_report("code6_again");
        ack_pulse();
        chk("code6_ackclr", 32'(key_valid), 32'h0);
        pressed = '0;
        watch(100);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
